// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared packed-BCD types, constants and digit validity helper
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX   = 4'd9;
    localparam logic [4:0] BCD_RADIX = 5'd10;

    function automatic logic is_bcd(input bcd_digit_t n);
        return (n <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// rtl/bcd_digit_sub.sv - one BCD digit of a - b - bin with decimal borrow correction
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       bin,
    output bcd_digit_t d,
    output logic       bout
);

    logic signed [4:0] diff;
    logic        [4:0] adj;

    // Five-bit signed difference; sign bit is the decimal borrow.
    assign diff = $signed({1'b0, a}) - $signed({1'b0, b}) - $signed({4'b0000, bin});
    assign adj  = diff + BCD_RADIX;
    assign bout = diff[4];
    assign d    = bout ? adj[3:0] : diff[3:0];

endmodule

// File: rtl/bcd_serial_sub.sv
// rtl/bcd_serial_sub.sv - digit-serial packed-BCD subtractor, LSD first, start/busy/done handshake
module bcd_serial_sub
    import bcd_pkg::*;
#(
    parameter int NDIG = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4*NDIG-1:0] A,
    input  logic [4*NDIG-1:0] B,
    input  logic              Bin,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG-1:0] D,
    output logic              Bout,
    output logic              err
);

    localparam int W  = 4 * NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]  a_sr, b_sr, d_q, res_nxt;
    logic          brw, bout_q, err_q, bad;
    logic [IW-1:0] idx;
    bcd_digit_t    dig_d;
    logic          dig_bout;

    bcd_digit_sub u_digit (
        .a    (a_sr[3:0]),
        .b    (b_sr[3:0]),
        .bin  (brw),
        .d    (dig_d),
        .bout (dig_bout)
    );

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (!is_bcd(A[4*i +: 4]) || !is_bcd(B[4*i +: 4])) begin
                bad = 1'b1;
            end
        end
    end

    always_comb begin
        res_nxt = d_q;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == IW'(i)) begin
                res_nxt[4*i +: 4] = dig_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (idx == LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            brw    <= 1'b0;
            idx    <= '0;
            d_q    <= '0;
            bout_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr   <= A;
                        b_sr   <= B;
                        brw    <= Bin;
                        idx    <= '0;
                        d_q    <= '0;
                        bout_q <= 1'b0;
                        err_q  <= bad;
                    end
                end
                S_RUN: begin
                    a_sr <= a_sr >> 4;
                    b_sr <= b_sr >> 4;
                    brw  <= dig_bout;
                    idx  <= idx + 1'b1;
                    d_q  <= res_nxt;
                    // An invalid operand still runs every digit but reports zero.
                    if (idx == LAST) begin
                        if (err_q) begin
                            d_q    <= '0;
                            bout_q <= 1'b0;
                        end else begin
                            bout_q <= dig_bout;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign D    = d_q;
    assign Bout = bout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_sub.sv
// tb/tb_bcd_serial_sub.sv - scoreboard bench for bcd_serial_sub against a decimal reference model
module tb_bcd_serial_sub;

    localparam int NDIG = 2;
    localparam int W    = 4 * NDIG;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic         Bin   = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         busy, done, Bout, err;
    logic [W-1:0] D;

    int n_checks   = 0;
    int n_fail     = 0;
    int done_count = 0;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bout;
        logic         err;
    } exp_t;

    exp_t sb[$];

    bcd_serial_sub #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bout  (Bout),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_count++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int av;
        int bv;
        int dv;
        logic [W-1:0] r;
        logic bo;
        av = 0;
        bv = 0;
        r  = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            av = av * 10 + int'(a[4*i +: 4]);
            bv = bv * 10 + int'(b[4*i +: 4]);
        end
        dv = av - bv - int'(bin);
        bo = 1'b0;
        if (dv < 0) begin
            dv = dv + 10 ** NDIG;
            bo = 1'b1;
        end
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(dv % 10);
            dv = dv / 10;
        end
        return {bo, r};
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input logic exp_err);
        exp_t e;
        logic [W:0] m;
        int n;
        m      = ref_sub(a, b, bin);
        e.d    = exp_err ? '0 : m[W-1:0];
        e.bout = exp_err ? 1'b0 : m[W];
        e.err  = exp_err;
        sb.push_back(e);
        @(negedge clk);
        A = a; B = b; Bin = bin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_after_start: got %b required 1", busy);
        if (busy !== 1'b1) n_fail++;
        n_checks++;
        if (err !== exp_err) begin
            $display("FAIL err_after_start: got %b required %b", err, exp_err);
            n_fail++;
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n != NDIG) begin
            $display("FAIL latency: done after %0d edges, required %0d", n, NDIG);
            n_fail++;
        end
        e = sb.pop_front();
        n_checks++;
        if (D !== e.d) begin
            $display("FAIL diff A=%h B=%h Bin=%b: D=%h required %h", a, b, bin, D, e.d);
            n_fail++;
        end
        n_checks++;
        if (Bout !== e.bout) begin
            $display("FAIL bout A=%h B=%h Bin=%b: Bout=%b required %b", a, b, bin, Bout, e.bout);
            n_fail++;
        end
        n_checks++;
        if (err !== e.err) begin
            $display("FAIL err_at_done A=%h B=%h: err=%b required %b", a, b, err, e.err);
            n_fail++;
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin
            $display("FAIL done_width: done=%b required 0", done);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, Bout, err} !== 4'b0000 || D !== '0) begin
            $display("FAIL reset_state: busy=%b done=%b D=%h Bout=%b err=%b required all 0", busy, done, D, Bout, err);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_op(8'h01, 8'h02, 1'b0, 1'b0);
        run_op(8'h99, 8'h72, 1'b0, 1'b0);
        run_op(8'h85, 8'h29, 1'b0, 1'b0);
        run_op(8'h45, 8'h55, 1'b0, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 1'b0);
        run_op(8'h99, 8'h99, 1'b0, 1'b0);
    endtask

    task automatic test_invalid();
        run_op(8'h5A, 8'h10, 1'b0, 1'b1);
        run_op(8'h12, 8'hF3, 1'b1, 1'b1);
        run_op(8'h50, 8'h20, 1'b0, 1'b0);
    endtask

    task automatic test_start_during_run();
        exp_t e;
        int dc0;
        int n;
        e.d = 8'h56; e.bout = 1'b0; e.err = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        A = 8'h85; B = 8'h29; Bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        dc0 = done_count;
        A = 8'h11; B = 8'h99; Bin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        n_checks++;
        if (D !== e.d || Bout !== e.bout) begin
            $display("FAIL start_ignored_result: D=%h Bout=%b required %h %b", D, Bout, e.d, e.bout);
            n_fail++;
        end
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (done_count - dc0 != 1) begin
            $display("FAIL start_ignored_pulses: %0d done pulses, required 1", done_count - dc0);
            n_fail++;
        end
    endtask

    task automatic test_reset_during_run();
        int dc0;
        @(negedge clk);
        A = 8'h85; B = 8'h29; Bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        dc0 = done_count;
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || D !== '0 || done !== 1'b0 || Bout !== 1'b0) begin
            $display("FAIL abort_outputs: busy=%b D=%h done=%b Bout=%b required 0", busy, D, done, Bout);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (done_count != dc0) begin
            $display("FAIL abort_no_done: %0d pulses after abort, required 0", done_count - dc0);
            n_fail++;
        end
        run_op(8'h29, 8'h02, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < NDIG; i++) begin
                a[4*i +: 4] = 4'($urandom_range(0, 9));
                b[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            run_op(a, b, 1'($urandom), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid();
        test_start_during_run();
        test_reset_during_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
